// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI4-Stream round-robin FIFO arbiter.
package axis_arb_pkg;

    localparam int unsigned TDEST_W   = 2;
    localparam int unsigned MAX_SRC   = 4;
    localparam int unsigned BEAT_CW   = 8;

    localparam logic [2:0] ST_IDLE_V = 3'b001;
    localparam logic [2:0] ST_READ_V = 3'b010;
    localparam logic [2:0] ST_SEND_V = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE = ST_IDLE_V,
        ST_READ = ST_READ_V,
        ST_SEND = ST_SEND_V
    } state_e;

    function automatic bit num_src_ok(input int unsigned n);
        return (n >= 2) && (n <= MAX_SRC);
    endfunction

endpackage

// File: rtl/axis_fifo_rr_arbiter_if.sv
// AXI4-Stream master-side bundle carrying one tagged beat per handshake.
interface axis_fifo_rr_arbiter_if
    import axis_arb_pkg::*;
#(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32
);
    logic                            TVALID;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] TDATA;
    logic [TDEST_W-1:0]              TDEST;
    logic                            TREADY;

    modport master (output TVALID, output TDATA, output TDEST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TDEST, output TREADY);
endinterface

// File: rtl/rr_priority_select.sv
// Round-robin first-one search: lowest index at or after last+1, wrapping at N.
module rr_priority_select
    import axis_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]       req,
    input  logic [TDEST_W-1:0] last,
    output logic [TDEST_W-1:0] gnt_idx,
    output logic               any
);

    logic [MAX_SRC-1:0] req_x;
    logic [2:0]         pos;

    assign req_x = MAX_SRC'(req);
    assign any   = |req;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        gnt_idx = '0;
        pos     = '0;
        for (int k = N; k >= 1; k--) begin
            pos = 3'(last) + 3'(k);
            if (pos >= 3'(N)) begin
                pos = pos - 3'(N);
            end
            if (req_x[pos[1:0]]) begin
                gnt_idx = pos[1:0];
            end
        end
    end

endmodule

// File: rtl/axis_fifo_rr_arbiter.sv
// Shares one AXI4-Stream master among C_NUM_SRC standard FIFOs, bursting
// up to C_MAX_BURST beats per grant and tagging each beat with its source.
module axis_fifo_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_NUM_SRC            = 2,
    parameter int unsigned C_MAX_BURST          = 16
) (
    input  logic                                      M_AXIS_ACLK,
    input  logic                                      M_AXIS_ARESET,
    axis_fifo_rr_arbiter_if.master                    M_AXIS,
    input  logic [C_NUM_SRC*C_M_AXIS_TDATA_WIDTH-1:0] fifo_dout,
    input  logic [C_NUM_SRC-1:0]                      fifo_empty,
    output logic [C_NUM_SRC-1:0]                      fifo_rd_en,
    input  logic [C_NUM_SRC-1:0]                      src_enable,
    output logic                                      busy
);

    localparam int unsigned W = C_M_AXIS_TDATA_WIDTH;

    if (!num_src_ok(C_NUM_SRC)) begin : g_bad_num_src
        $error("axis_fifo_rr_arbiter: C_NUM_SRC must be 2..4");
    end
    if ((C_MAX_BURST < 1) || (C_MAX_BURST > 255)) begin : g_bad_burst
        $error("axis_fifo_rr_arbiter: C_MAX_BURST must be 1..255");
    end

    state_e               state_q;
    logic [TDEST_W-1:0]   grant_q;
    logic [TDEST_W-1:0]   last_grant_q;
    logic [BEAT_CW-1:0]   beat_cnt_q;

    logic [C_NUM_SRC-1:0] eligible_c;
    logic [TDEST_W-1:0]   sel_idx_c;
    logic                 sel_any_c;
    logic [MAX_SRC-1:0]   empty_x_c;
    logic [MAX_SRC-1:0]   enable_x_c;
    logic [MAX_SRC-1:0]   rd_x_c;
    logic [W-1:0]         dout_arr_c [MAX_SRC];
    logic                 hs_c;
    logic                 burst_done_c;
    logic                 release_c;

    // Unpack FIFO outputs into a full-size array so a 2-bit grant always indexes in range.
    for (genvar g = 0; g < int'(MAX_SRC); g++) begin : g_dout
        if (g < int'(C_NUM_SRC)) begin : g_src
            assign dout_arr_c[g] = fifo_dout[g*W +: W];
        end else begin : g_pad
            assign dout_arr_c[g] = '0;
        end
    end

    assign empty_x_c  = MAX_SRC'(fifo_empty);
    assign enable_x_c = MAX_SRC'(src_enable);
    assign eligible_c = src_enable & ~fifo_empty;

    rr_priority_select #(
        .N (C_NUM_SRC)
    ) u_sel (
        .req     (eligible_c),
        .last    (last_grant_q),
        .gnt_idx (sel_idx_c),
        .any     (sel_any_c)
    );

    assign hs_c         = (state_q == ST_SEND) && M_AXIS.TREADY;
    assign burst_done_c = (9'(beat_cnt_q) + 9'd1) == 9'(C_MAX_BURST);
    assign release_c    = burst_done_c || empty_x_c[grant_q] || !enable_x_c[grant_q];

    // Pop on entering SEND and on every non-final handshake; never pop an empty FIFO.
    always_comb begin
        rd_x_c = '0;
        if (((state_q == ST_READ) || (hs_c && !release_c)) && !empty_x_c[grant_q]) begin
            rd_x_c[grant_q] = 1'b1;
        end
    end

    assign fifo_rd_en = rd_x_c[C_NUM_SRC-1:0];

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            beat_cnt_q   <= '0;
            last_grant_q <= TDEST_W'(C_NUM_SRC - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_any_c) begin
                        grant_q    <= sel_idx_c;
                        beat_cnt_q <= '0;
                        state_q    <= ST_READ;
                    end
                end
                ST_READ: begin
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (hs_c) begin
                        beat_cnt_q <= beat_cnt_q + BEAT_CW'(1);
                        if (release_c) begin
                            last_grant_q <= grant_q;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // TVALID/TDEST/busy decode straight from registers; TDATA is the held FIFO word.
    assign M_AXIS.TVALID = (state_q == ST_SEND);
    assign M_AXIS.TDATA  = dout_arr_c[grant_q];
    assign M_AXIS.TDEST  = grant_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
// Directed bench for axis_fifo_rr_arbiter with two modelled standard FIFOs.
module tb_axis_fifo_rr_arbiter;

    localparam int unsigned W = 32;

    typedef struct {
        logic        tready;
        logic [1:0]  en;
        logic        valid;
        logic [31:0] data;
        logic [1:0]  dest;
        logic        busy;
        logic [1:0]  rd;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*W-1:0] fifo_dout;
    logic [1:0]    fifo_empty;
    logic [1:0]    fifo_rd_en;
    logic [1:0]    src_enable;
    logic          busy;

    int total = 0;
    int bad   = 0;

    axis_fifo_rr_arbiter_if #(.C_M_AXIS_TDATA_WIDTH(W)) m_axis ();

    axis_fifo_rr_arbiter #(
        .C_M_AXIS_TDATA_WIDTH (W),
        .C_NUM_SRC            (2),
        .C_MAX_BURST          (4)
    ) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (rst),
        .M_AXIS        (m_axis),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .src_enable    (src_enable),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Standard FIFO model: word appears on dout the cycle after rd_en.
    logic [31:0] mem [2][64];
    int unsigned wp [2] = '{0, 0};
    int unsigned rp [2] = '{0, 0};
    logic [31:0] dout_m [2] = '{32'h0, 32'h0};

    assign fifo_dout     = {dout_m[1], dout_m[0]};
    assign fifo_empty[0] = (rp[0] == wp[0]);
    assign fifo_empty[1] = (rp[1] == wp[1]);

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fifo_rd_en[i] && (rp[i] != wp[i])) begin
                dout_m[i] <= mem[i][rp[i] % 64];
                rp[i]     <= rp[i] + 1;
            end
        end
    end

    // Read strobes must be one-hot-or-zero and never hit an empty FIFO.
    always @(posedge clk) begin
        total++;
        if ((fifo_rd_en & fifo_empty) != 2'b00) begin
            bad++;
            $display("FAIL rd_gate: rd_en=%b empty=%b (must not overlap)", fifo_rd_en, fifo_empty);
        end
        total++;
        if (!$onehot0(fifo_rd_en)) begin
            bad++;
            $display("FAIL rd_onehot: rd_en=%b", fifo_rd_en);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [31:0] val);
        mem[s][wp[s] % 64] = val;
        wp[s] = wp[s] + 1;
    endtask

    function automatic vec_t mk(input logic tr, input logic [1:0] en, input logic v,
                                input logic [31:0] d, input logic [1:0] dst,
                                input logic b, input logic [1:0] rd);
        vec_t r;
        r.tready = tr; r.en = en; r.valid = v; r.data = d;
        r.dest = dst; r.busy = b; r.rd = rd;
        return r;
    endfunction

    task automatic apply_chk(input vec_t v, input string tag);
        m_axis.TREADY = v.tready;
        src_enable    = v.en;
        #1;
        chk({tag, ".valid"}, 32'(m_axis.TVALID), 32'(v.valid));
        chk({tag, ".dest"},  32'(m_axis.TDEST),  32'(v.dest));
        chk({tag, ".busy"},  32'(busy),          32'(v.busy));
        chk({tag, ".rd_en"}, 32'(fifo_rd_en),    32'(v.rd));
        if (v.valid) chk({tag, ".data"}, m_axis.TDATA, v.data);
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        apply_chk(v, tag);
    endtask

    vec_t tbl [12];

    initial begin
        int beats;
        int n0;
        int n1;
        int exp_src;
        logic [31:0] exp_d;

        // Single source, burst cap of 4: A0..A3, two idle cycles, A4..A5.
        tbl[0]  = mk(1'b1, 2'b11, 1'b0, 32'h0,  2'd0, 1'b0, 2'b00);
        tbl[1]  = mk(1'b1, 2'b11, 1'b0, 32'h0,  2'd0, 1'b1, 2'b01);
        tbl[2]  = mk(1'b1, 2'b11, 1'b1, 32'hA0, 2'd0, 1'b1, 2'b01);
        tbl[3]  = mk(1'b1, 2'b11, 1'b1, 32'hA1, 2'd0, 1'b1, 2'b01);
        tbl[4]  = mk(1'b1, 2'b11, 1'b1, 32'hA2, 2'd0, 1'b1, 2'b01);
        tbl[5]  = mk(1'b1, 2'b11, 1'b1, 32'hA3, 2'd0, 1'b1, 2'b00);
        tbl[6]  = mk(1'b1, 2'b11, 1'b0, 32'h0,  2'd0, 1'b0, 2'b00);
        tbl[7]  = mk(1'b1, 2'b11, 1'b0, 32'h0,  2'd0, 1'b1, 2'b01);
        tbl[8]  = mk(1'b1, 2'b11, 1'b1, 32'hA4, 2'd0, 1'b1, 2'b01);
        tbl[9]  = mk(1'b1, 2'b11, 1'b1, 32'hA5, 2'd0, 1'b1, 2'b00);
        tbl[10] = mk(1'b1, 2'b11, 1'b0, 32'h0,  2'd0, 1'b0, 2'b00);
        tbl[11] = mk(1'b1, 2'b11, 1'b0, 32'h0,  2'd0, 1'b0, 2'b00);

        rst           = 1'b1;
        m_axis.TREADY = 1'b0;
        src_enable    = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset.valid", 32'(m_axis.TVALID), 32'd0);
        chk("reset.rd_en", 32'(fifo_rd_en),    32'd0);
        chk("reset.dest",  32'(m_axis.TDEST),  32'd0);
        chk("reset.busy",  32'(busy),          32'd0);
        for (int k = 0; k < 6; k++) push(0, 32'hA0 + 32'(k));
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i], $sformatf("burst[%0d]", i));
        end

        // Backpressure plus early empty on source 1 (3 words).
        @(negedge clk);
        push(1, 32'hB0); push(1, 32'hB1); push(1, 32'hB2);
        apply_chk(mk(1'b1, 2'b11, 1'b0, 32'h0,  2'd0, 1'b0, 2'b00), "bp0");
        step(mk(1'b1, 2'b11, 1'b0, 32'h0,  2'd1, 1'b1, 2'b10), "bp1");
        step(mk(1'b1, 2'b11, 1'b1, 32'hB0, 2'd1, 1'b1, 2'b10), "bp2");
        step(mk(1'b0, 2'b11, 1'b1, 32'hB1, 2'd1, 1'b1, 2'b00), "bp3");
        step(mk(1'b0, 2'b11, 1'b1, 32'hB1, 2'd1, 1'b1, 2'b00), "bp4");
        step(mk(1'b1, 2'b11, 1'b1, 32'hB1, 2'd1, 1'b1, 2'b10), "bp5");
        step(mk(1'b1, 2'b11, 1'b1, 32'hB2, 2'd1, 1'b1, 2'b00), "bp6");
        step(mk(1'b1, 2'b11, 1'b0, 32'h0,  2'd1, 1'b0, 2'b00), "bp7");

        // Enable mask: only source 1 granted; clearing it releases after the current beat.
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            push(0, 32'hE0 + 32'(k));
            push(1, 32'hF0 + 32'(k));
        end
        apply_chk(mk(1'b1, 2'b10, 1'b0, 32'h0,  2'd1, 1'b0, 2'b00), "en0");
        step(mk(1'b1, 2'b10, 1'b0, 32'h0,  2'd1, 1'b1, 2'b10), "en1");
        step(mk(1'b1, 2'b10, 1'b1, 32'hF0, 2'd1, 1'b1, 2'b10), "en2");
        step(mk(1'b1, 2'b00, 1'b1, 32'hF1, 2'd1, 1'b1, 2'b00), "en3");
        step(mk(1'b1, 2'b00, 1'b0, 32'h0,  2'd1, 1'b0, 2'b00), "en4");
        step(mk(1'b1, 2'b00, 1'b0, 32'h0,  2'd1, 1'b0, 2'b00), "en5");

        // Fairness: 12 words on source 0, 8 on source 1; bursts of 4 rotate 0,1,0,1,0.
        @(negedge clk);
        wp[0] = rp[0];
        wp[1] = rp[1];
        for (int k = 0; k < 12; k++) push(0, 32'h100 + 32'(k));
        for (int k = 0; k < 8; k++)  push(1, 32'h200 + 32'(k));
        m_axis.TREADY = 1'b1;
        src_enable    = 2'b11;
        beats = 0; n0 = 0; n1 = 0;
        for (int cyc = 0; cyc < 200 && beats < 20; cyc++) begin
            @(negedge clk);
            #1;
            if (m_axis.TVALID) begin
                exp_src = (beats / 4) % 2;
                if (exp_src == 1) begin
                    exp_d = 32'h200 + 32'(n1);
                    n1++;
                end else begin
                    exp_d = 32'h100 + 32'(n0);
                    n0++;
                end
                chk($sformatf("fair%0d.dest", beats), 32'(m_axis.TDEST), 32'(exp_src));
                chk($sformatf("fair%0d.data", beats), m_axis.TDATA, exp_d);
                beats++;
            end
        end
        chk("fair.beats", 32'(beats), 32'd20);

        // Reset mid-burst: popped word dropped, FIFO not rewound, source 0 wins afterwards.
        step(mk(1'b1, 2'b11, 1'b0, 32'h0, 2'd0, 1'b0, 2'b00), "rs_idle");
        @(negedge clk);
        for (int k = 0; k < 4; k++) push(0, 32'h300 + 32'(k));
        apply_chk(mk(1'b1, 2'b11, 1'b0, 32'h0,   2'd0, 1'b0, 2'b00), "rs0");
        step(mk(1'b1, 2'b11, 1'b0, 32'h0,   2'd0, 1'b1, 2'b01), "rs1");
        @(negedge clk);
        push(1, 32'h400); push(1, 32'h401);
        apply_chk(mk(1'b0, 2'b11, 1'b1, 32'h300, 2'd0, 1'b1, 2'b00), "rs2");
        @(negedge clk);
        rst = 1'b1;
        apply_chk(mk(1'b0, 2'b11, 1'b1, 32'h300, 2'd0, 1'b1, 2'b00), "rs3");
        @(negedge clk);
        rst = 1'b0;
        apply_chk(mk(1'b1, 2'b11, 1'b0, 32'h0,   2'd0, 1'b0, 2'b00), "rs_post");
        step(mk(1'b1, 2'b11, 1'b0, 32'h0,   2'd0, 1'b1, 2'b01), "rs_read");
        step(mk(1'b1, 2'b11, 1'b1, 32'h301, 2'd0, 1'b1, 2'b01), "rs_send");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_fifo_rr_arbiter.md
# axis_fifo_rr_arbiter

Round-robin scheduler that shares one AXI4-Stream master port between C_NUM_SRC first-word standard FIFOs. It grants one source at a time, drains it for up to C_MAX_BURST beats, then rotates. It drives each FIFO's `fifo_rd_en` and tags every beat with the source index on M_AXIS_TDEST. It sits between the per-channel input FIFOs and the single downstream stream sink.

## Interface
- C_M_AXIS_TDATA_WIDTH, 32, stream and FIFO data width
- C_NUM_SRC, 2, number of FIFO sources; legal range 2..4
- C_MAX_BURST, 16, maximum beats per grant; legal range 1..255
- M_AXIS_ACLK  in  1  single clock; all logic on its rising edge
- M_AXIS_ARESET  in  1  reset; synchronous, active-high
- M_AXIS_TVALID  out  1  beat valid
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  beat payload, muxed from the granted FIFO output
- M_AXIS_TDEST  out  2  index of the granted source
- M_AXIS_TREADY  in  1  sink ready
- fifo_dout  in  C_NUM_SRC*C_M_AXIS_TDATA_WIDTH  flattened FIFO outputs; source i occupies bits [i*W +: W]
- fifo_empty  in  C_NUM_SRC  per-source empty flag
- fifo_rd_en  out  C_NUM_SRC  per-source read strobe; data is valid the cycle after it is asserted and held until the next strobe
- src_enable  in  C_NUM_SRC  per-source arbitration mask; 0 excludes the source from new grants
- busy  out  1  high whenever the state is not IDLE

## Operation
- **State machine**, one-hot: IDLE=3'b001, READ=3'b010, SEND=3'b100.
- **IDLE**
  - Eligible sources: `src_enable[i] & ~fifo_empty[i]`.
  - If any source is eligible, register `grant` as the first eligible index searching upward from `last_grant+1`, with wrap. Clear `beat_cnt`. Go to READ.
  - Otherwise stay in IDLE.
- **READ**
  - `fifo_rd_en[grant]=1` for exactly one cycle. Go to SEND.
- **SEND**
  - M_AXIS_TVALID=1. M_AXIS_TDATA = `fifo_dout[grant]`. M_AXIS_TDEST = `grant`.
  - On handshake (TVALID & TREADY), `beat_cnt` increments. Then:
    - **Release** if `beat_cnt+1==C_MAX_BURST`, or `fifo_empty[grant]`, or `~src_enable[grant]`. On release: `last_grant <= grant`, go to IDLE, no read strobe.
    - **Continue** otherwise: `fifo_rd_en[grant]=1` in the same cycle (combinational), and stay in SEND.
  - Without a handshake, hold state, TDATA and TDEST, and do not read.
- **Gating**
  - `fifo_rd_en` is never asserted for a source whose `fifo_empty` is 1.
  - At most one bit of `fifo_rd_en` is high in any cycle.
- **Arithmetic**
  - `beat_cnt` is 8 bits; the compare uses a 9-bit sum, so there is no wrap.
  - `last_grant` wraps modulo C_NUM_SRC.
- **Reset values**
  - Outputs: TVALID=0, `fifo_rd_en`=0, TDEST=0, `busy`=0.
  - Internal: state=IDLE, `grant`=0, `beat_cnt`=0, `last_grant`=C_NUM_SRC-1, so source 0 wins first.
- **Boundary conditions**
  - Reset asserted mid-burst: a word already popped and not yet accepted is discarded, and the FIFO is not rewound.
  - Clearing `src_enable` during SEND: the current beat still completes, then the grant is released.
  - Source becoming eligible while another holds the grant: it waits for that grant's release.
  - All sources eligible simultaneously: strict rotation 0,1,…,N-1,0.

## Timing
- Latency from `fifo_empty[i]` falling in IDLE to TVALID rising: 2 cycles (IDLE→READ→SEND).
- Within a burst with TREADY=1: one beat per cycle.
- Grant switch overhead: 2 idle cycles between the last beat of one burst and the first beat of the next (IDLE, READ).
- TVALID, once high, stays high with TDATA and TDEST stable until the handshake.

## Structure
- **Shared package `axis_arb_pkg`**: state one-hot localparams, the TDEST width constant (2), and the C_NUM_SRC legality check.
- **Sub-module `rr_priority_select`**: combinational round-robin first-one search with inputs `req[N]` and `last[2]`, outputs `gnt_idx[2]` and `any`. It is instantiated once.

## Test plan
- **Single source, burst cap**: N=2, MAX_BURST=4. Source 0 preloaded with 0xA0..0xA5, TREADY=1. Required: beats 0xA0..0xA3 with TDEST=0, a 2-cycle gap, then 0xA4,0xA5.
- **Round-robin fairness**: both FIFOs full, MAX_BURST=2, TREADY=1. Required TDEST sequence 0,0,1,1,0,0,1,1; each source receives exactly 2 beats per grant.
- **Backpressure**: TREADY toggles 1,0,0,1 during a burst. Required: TDATA held stable while TREADY=0, no `fifo_rd_en` during stall cycles, and no lost or duplicated words when compared against the scoreboard.
- **Early empty**: source 1 holds 3 words, MAX_BURST=16. Required: 3 beats, then release to IDLE with `busy`=0 one cycle after the third handshake; `fifo_rd_en[1]` is never high while `fifo_empty[1]`=1.
- **Enable mask**: set `src_enable`=2'b10 with both FIFOs non-empty. Required: only TDEST=1 appears. Clear bit 1 mid-burst: the current beat completes, then the block goes to IDLE and stays there.
- **Reset mid-burst**: assert M_AXIS_ARESET for 1 cycle during SEND. Required next cycle: TVALID=0, `fifo_rd_en`=0, `busy`=0. The first post-reset grant goes to source 0 when both sources are eligible.
